// File: rtl/lcd_cmd_fifo.sv
// lcd_cmd_fifo
// Buffers {cmd, data} write strobes from the upstream interface FSM and plays
// them out on a 4-bit HD44780-style LCD bus. Every setup, pulse, gap and
// execution delay comes from a single 20-bit down-counter.
// Build option: define LCD_INIT_EN to compile in the power-on initialisation
// sequence. Without it, the panel is assumed ready one clock after reset.
module lcd_cmd_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned T_PWR = 750000,
  parameter int unsigned T_W1  = 205000,
  parameter int unsigned T_W2  = 5000,
  parameter int unsigned T_NIB = 50,
  parameter int unsigned T_CMD = 2000,
  parameter int unsigned T_CLR = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       cmd,
  input  logic [7:0] data,
  output logic       buf_full,
  output logic       overflow,
  output logic       init_done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] lcd_d
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // Counter load values: a state lasting N cycles is entered with N-1.
  localparam logic [19:0] LD_SETUP = 20'd1;
  localparam logic [19:0] LD_PULSE = 20'd11;
  localparam logic [19:0] LD_HOLD  = 20'd0;
  localparam logic [19:0] LD_NIB   = 20'(T_NIB - 1);
  localparam logic [19:0] LD_CMD   = 20'(T_CMD - 1);
  localparam logic [19:0] LD_CLR   = 20'(T_CLR - 1);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_POP   = 4'd1;
  localparam logic [3:0] S_SETUP = 4'd2;
  localparam logic [3:0] S_PULSE = 4'd3;
  localparam logic [3:0] S_HOLD  = 4'd4;
  localparam logic [3:0] S_GAP   = 4'd5;
  localparam logic [3:0] S_WAIT  = 4'd6;
`ifdef LCD_INIT_EN
  localparam logic [3:0] S_BOOT  = 4'd7;
  localparam logic [3:0] S_PWR   = 4'd8;
  localparam logic [3:0] S_RESET = S_BOOT;
`else
  localparam logic [3:0] S_RESET = S_IDLE;
`endif

  // ---------------------------------------------------------------- FIFO
  logic          en_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [8:0]    mem [DEPTH];
  logic [8:0]    head;
  logic          push, push_ok, pop, fifo_full;

  // --------------------------------------------------------------- engine
  logic [3:0]  state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [8:0]  byte_q, byte_d;     // {rs, data} of the byte on the bus
  logic        hi_q, hi_d;         // currently sending the high nibble
  logic        single_q, single_d; // lone init nibble, no low half follows
  logic        lcd_rs_q, lcd_rs_d;
  logic [3:0]  lcd_d_q, lcd_d_d;
  logic        init_done_q, init_done_d;
  logic [19:0] byte_wait, nib_wait;

`ifdef LCD_INIT_EN
  logic [2:0] init_step_q, init_step_d; // 0-3 single nibbles, 4-7 bytes

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    init_byte = 8'h28; // 4-bit bus, 2 lines, 5x8 font
      2'd1:    init_byte = 8'h06; // entry mode: increment, no shift
      2'd2:    init_byte = 8'h0C; // display on, cursor off
      default: init_byte = 8'h01; // clear display
    endcase
  endfunction

  // Wait after each lone init nibble: long, medium, then ordinary.
  always_comb begin
    case (init_step_q)
      3'd0:    nib_wait = 20'(T_W1 - 1);
      3'd1:    nib_wait = 20'(T_W2 - 1);
      default: nib_wait = LD_CMD;
    endcase
  end
`else
  assign nib_wait = LD_CMD;
  logic unused_init_params;
  assign unused_init_params = ^{T_PWR, T_W1, T_W2};
`endif

  assign head      = mem[rd_ptr_q];
  assign buf_full  = !init_done_q || (count_q >= CW'(DEPTH - 2));
  assign overflow  = overflow_q;
  assign init_done = init_done_q;
  assign lcd_e     = (state_q == S_PULSE);
  assign lcd_rs    = lcd_rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_d     = lcd_d_q;

  // Clear and return-home instructions need the long execution wait.
  assign byte_wait = (!byte_q[8] && (byte_q[7:0] == 8'h01 || byte_q[7:0] == 8'h02))
                     ? LD_CLR : LD_CMD;

  // Edge-detected write, pointer and occupancy bookkeeping.
  always_comb begin
    push       = en & ~en_q;
    fifo_full  = (count_q == CW'(DEPTH));
    push_ok    = push & ~fifo_full;
    pop        = (state_q == S_POP);
    overflow_d = overflow_q | (push & fifo_full);
    wr_ptr_d   = wr_ptr_q + AW'(push_ok);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + CW'(push_ok) - CW'(pop);
  end

  // Storage array; write-only port here, read through the POP latch.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= {~cmd, data};
  end

  // Byte / nibble sequencer and optional initialisation walk.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    byte_d      = byte_q;
    hi_d        = hi_q;
    single_d    = single_q;
    lcd_rs_d    = lcd_rs_q;
    lcd_d_d     = lcd_d_q;
`ifdef LCD_INIT_EN
    init_done_d = init_done_q;
    init_step_d = init_step_q;
`else
    init_done_d = 1'b1;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef LCD_INIT_EN
        if (!init_done_q) begin
          lcd_rs_d = 1'b0;
          state_d  = S_SETUP;
          cnt_d    = LD_SETUP;
          if (init_step_q < 3'd4) begin
            single_d = 1'b1;
            hi_d     = 1'b0;
            lcd_d_d  = (init_step_q == 3'd3) ? 4'h2 : 4'h3;
          end else begin
            single_d = 1'b0;
            hi_d     = 1'b1;
            byte_d   = {1'b0, init_byte(init_step_q[1:0])};
            lcd_d_d  = init_byte(init_step_q[1:0]) >> 4;
          end
        end else
`endif
        if (count_q != '0) state_d = S_POP;
      end
      S_POP: begin
        byte_d   = head;
        hi_d     = 1'b1;
        single_d = 1'b0;
        lcd_rs_d = head[8];
        lcd_d_d  = head[7:4];
        state_d  = S_SETUP;
        cnt_d    = LD_SETUP;
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_PULSE;
          cnt_d   = LD_PULSE;
        end else cnt_d = cnt_q - 20'd1;
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = LD_HOLD;
        end else cnt_d = cnt_q - 20'd1;
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          if (single_q) begin
            state_d = S_WAIT;
            cnt_d   = nib_wait;
          end else if (hi_q) begin
            state_d = S_GAP;
            cnt_d   = LD_NIB;
          end else begin
            state_d = S_WAIT;
            cnt_d   = byte_wait;
          end
        end else cnt_d = cnt_q - 20'd1;
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          hi_d    = 1'b0;
          lcd_d_d = byte_q[3:0];
          state_d = S_SETUP;
          cnt_d   = LD_SETUP;
        end else cnt_d = cnt_q - 20'd1;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
`ifdef LCD_INIT_EN
          if (!init_done_q) begin
            init_step_d = init_step_q + 3'd1;
            if (init_step_q == 3'd7) init_done_d = 1'b1;
          end
`endif
        end else cnt_d = cnt_q - 20'd1;
      end
`ifdef LCD_INIT_EN
      S_BOOT: begin
        state_d = S_PWR;
        cnt_d   = 20'(T_PWR - 1);
      end
      S_PWR: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else cnt_d = cnt_q - 20'd1;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset empties the FIFO and parks the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q        <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      state_q     <= S_RESET;
      cnt_q       <= '0;
      byte_q      <= '0;
      hi_q        <= 1'b0;
      single_q    <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_d_q     <= '0;
      init_done_q <= 1'b0;
`ifdef LCD_INIT_EN
      init_step_q <= '0;
`endif
    end else begin
      en_q        <= en;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      byte_q      <= byte_d;
      hi_q        <= hi_d;
      single_q    <= single_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_d_q     <= lcd_d_d;
      init_done_q <= init_done_d;
`ifdef LCD_INIT_EN
      init_step_q <= init_step_d;
`endif
    end
  end

endmodule

// File: tb/tb_lcd_cmd_fifo.sv
// tb_lcd_cmd_fifo
// Drives write strobes into lcd_cmd_fifo and watches the LCD bus. Expected
// nibbles and inter-nibble timing come from a byte-level model: each accepted
// byte yields a high then low nibble with RS = ~cmd, and the gap before the
// next byte depends on whether the previous byte was a clear/home instruction.
module tb_lcd_cmd_fifo;
  localparam int DEPTH = 16;
  localparam int T_PWR = 10;
  localparam int T_W1  = 10;
  localparam int T_W2  = 10;
  localparam int T_NIB = 7;
  localparam int T_CMD = 40;
  localparam int T_CLR = 150;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       cmd = 1'b0;
  logic [7:0] data = 8'h00;
  logic       buf_full, overflow, init_done, lcd_e, lcd_rs, lcd_rw;
  logic [3:0] lcd_d;

  always #5 clk = ~clk;

  lcd_cmd_fifo #(
    .DEPTH(DEPTH), .T_PWR(T_PWR), .T_W1(T_W1), .T_W2(T_W2),
    .T_NIB(T_NIB), .T_CMD(T_CMD), .T_CLR(T_CLR)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .cmd(cmd), .data(data),
    .buf_full(buf_full), .overflow(overflow), .init_done(init_done),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_d(lcd_d)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic chk(input string tag, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, got, got, want, want);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ------------------------------------------------------- bus monitor
  typedef struct {
    logic       rs;
    logic [3:0] nib;
    int         rise;
    int         fall;
    bit         stable;
    bit         setup_ok;
  } nib_obs_t;
  nib_obs_t obs_q[$];
  bit mon_en = 1'b0;

  initial begin
    logic       e_prev;
    logic [4:0] h1, h2, cur_v;
    int         cur_rise;
    bit         cur_stable, cur_setup;
    e_prev = 1'b0; h1 = '0; h2 = '0; cur_v = '0;
    cur_rise = 0; cur_stable = 1'b0; cur_setup = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (lcd_e && !e_prev) begin
          cur_v      = {lcd_rs, lcd_d};
          cur_rise   = cyc;
          cur_setup  = (h1 == cur_v) && (h2 == cur_v);
          cur_stable = 1'b1;
        end else if (lcd_e) begin
          if ({lcd_rs, lcd_d} != cur_v) cur_stable = 1'b0;
        end else if (e_prev) begin
          if ({lcd_rs, lcd_d} != cur_v) cur_stable = 1'b0;
          obs_q.push_back('{rs: cur_v[4], nib: cur_v[3:0], rise: cur_rise,
                            fall: cyc, stable: cur_stable, setup_ok: cur_setup});
        end
      end
      e_prev = lcd_e;
      h2 = h1;
      h1 = {lcd_rs, lcd_d};
    end
  end

  // ------------------------------------------------------- reference model
  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         mode; // gap to previous byte: 0 unchecked, 1 at least, 2 exact
  } exp_byte_t;
  exp_byte_t exp_q[$];

  function automatic int wait_for(input logic rs, input logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02)) ? T_CLR : T_CMD;
  endfunction

  task automatic add_exp(input logic c, input logic [7:0] d, input int mode);
    exp_q.push_back('{rs: ~c, d: d, mode: mode});
  endtask

  task automatic push(input logic c, input logic [7:0] d, input int hold, output int t0);
    @(posedge clk);
    #1;
    t0 = cyc; en = 1'b1; cmd = c; data = d;
    repeat (hold) @(posedge clk);
    #1;
    en = 1'b0; cmd = 1'($urandom); data = 8'($urandom);
  endtask

  task automatic wait_obs(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (obs_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (obs_q.size() < n) chk({tag, "_timeout"}, obs_q.size(), n);
  endtask

  // Nibble on/off times: E high 12 cycles; E low between halves of a byte is
  // HOLD + GAP + SETUP; between queued bytes it is HOLD + WAIT + IDLE + POP + SETUP.
  task automatic score(input string tag);
    nib_obs_t  hi, lo;
    exp_byte_t e;
    int        prev_fall, prev_wait, gap;
    prev_fall = 0; prev_wait = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() < 2) begin
        chk({tag, "_missing_nibbles"}, obs_q.size(), 2);
        exp_q.delete();
        break;
      end
      hi = obs_q.pop_front();
      lo = obs_q.pop_front();
      $display("%s: byte rs=%0d data=0x%02h bus=%0h%0h", tag, e.rs, e.d, hi.nib, lo.nib);
      chk({tag, "_hi_nib"}, {hi.rs, hi.nib}, {e.rs, e.d[7:4]});
      chk({tag, "_lo_nib"}, {lo.rs, lo.nib}, {e.rs, e.d[3:0]});
      chk({tag, "_pulse_w"}, (hi.fall - hi.rise) + (lo.fall - lo.rise), 24);
      chk({tag, "_stable"}, hi.stable & hi.setup_ok & lo.stable & lo.setup_ok, 1);
      chk({tag, "_nib_gap"}, lo.rise - hi.fall, T_NIB + 3);
      gap = hi.rise - prev_fall;
      if (e.mode == 2) chk({tag, "_byte_gap"}, gap, prev_wait + 5);
      else if (e.mode == 1) chk({tag, "_byte_gap_min"}, int'(gap >= prev_wait + 5), 1);
      prev_fall = lo.fall;
      prev_wait = wait_for(e.rs, e.d);
    end
    chk({tag, "_extra_nibbles"}, obs_q.size(), 0);
    obs_q.delete();
  endtask

`ifdef LCD_INIT_EN
  task automatic init_seq(input string tag);
    logic [3:0] want [12];
    int  k;
    bit  bf_ok;
    want = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
    k = 0; bf_ok = 1'b1;
    while (!init_done && k < 20000) begin
      @(negedge clk);
      if (!buf_full) bf_ok = 1'b0;
      k++;
    end
    chk({tag, "_init_done"}, init_done, 1);
    chk({tag, "_bf_during_init"}, bf_ok, 1);
    chk({tag, "_init_count"}, obs_q.size(), 12);
    for (int i = 0; i < 12 && obs_q.size() > 0; i++) begin
      nib_obs_t o;
      o = obs_q.pop_front();
      $display("%s: init nibble %0d rs=%0d d=%0h", tag, i, o.rs, o.nib);
      chk({tag, "_init_nib"}, {o.rs, o.nib}, {1'b0, want[i]});
    end
    obs_q.delete();
  endtask
`endif

  // ------------------------------------------------------- stimulus
  initial begin
    int         t0, k, model_cnt;
    bit         model_ovf;
    logic       c;
    logic [7:0] d;
    nib_obs_t   first;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_lcd_e", lcd_e, 0);
    chk("rst_lcd_rs", lcd_rs, 0);
    chk("rst_lcd_rw", lcd_rw, 0);
    chk("rst_lcd_d", lcd_d, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_buf_full", buf_full, 1);
    rst = 1'b0;
    mon_en = 1'b1;
`ifdef LCD_INIT_EN
    init_seq("init");
`else
    @(posedge clk);
    #1;
    chk("rel_init_done", init_done, 1);
    chk("rel_buf_full", buf_full, 0);
`endif

    // Basic data write and first-E latency.
    push(1'b0, 8'h41, 1, t0);
    add_exp(1'b0, 8'h41, 0);
    wait_obs(2, 500, "basic");
    if (obs_q.size() > 0) begin
      first = obs_q[0];
      chk("basic_latency", first.rise - t0, 5);
    end
    repeat (T_CLR + 20) @(posedge clk);
    score("basic");

    // Clear instruction with a byte queued behind it.
    push(1'b1, 8'h01, 1, t0);
    add_exp(1'b1, 8'h01, 0);
    push(1'b0, 8'h20, 1, t0);
    add_exp(1'b0, 8'h20, 2);
    wait_obs(4, 2000, "clear");
    repeat (T_CLR + 20) @(posedge clk);
    score("clear");

    // Strobe held high for several cycles.
    push(1'b0, 8'hA5, 5, t0);
    add_exp(1'b0, 8'hA5, 0);
    wait_obs(2, 500, "held");
    repeat (T_CLR + 20) @(posedge clk);
    score("held");

    // Random traffic obeying back-pressure.
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 60)) @(posedge clk);
      #1;
      k = 0;
      while (buf_full && k < 5000) begin
        @(posedge clk);
        #1;
        k++;
      end
      if (buf_full) chk("rnd_bp_timeout", buf_full, 0);
      c = 1'($urandom);
      d = 8'($urandom);
      if (i % 10 == 3) begin c = 1'b1; d = 8'h01; end
      else if (i % 10 == 7) begin c = 1'b1; d = 8'h02; end
      else if (i % 10 == 5) begin c = 1'b0; d = 8'h01; end
      push(c, d, $urandom_range(1, 4), t0);
      add_exp(c, d, (i == 0) ? 0 : 1);
    end
    wait_obs(60, 30000, "rnd");
    repeat (T_CLR + 20) @(posedge clk);
    chk("rnd_overflow", overflow, 0);
    score("rnd");

    // Fill to capacity behind a busy engine, then one dropped write.
    c = 1'b0;
    d = 8'($urandom);
    push(c, d, 1, t0);
    add_exp(c, d, 0);
    k = 0;
    while (!lcd_e && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("fill_busy", lcd_e, 1);
    model_cnt = 0;
    model_ovf = 1'b0;
    for (int i = 1; i <= DEPTH + 1; i++) begin
      c = 1'b0;
      d = 8'($urandom);
      push(c, d, 1, t0);
      if (model_cnt < DEPTH) begin
        model_cnt++;
        add_exp(c, d, 2);
      end else model_ovf = 1'b1;
      chk("fill_buf_full", buf_full, int'(model_cnt >= DEPTH - 2));
      chk("fill_overflow", overflow, model_ovf);
    end
    wait_obs(2 * (DEPTH + 1), 5000, "fill");
    repeat (T_CLR + 20) @(posedge clk);
    chk("fill_overflow_sticky", overflow, 1);
    score("fill");

    // Reset in the middle of an E pulse with a byte still queued.
    push(1'b0, 8'h55, 1, t0);
    push(1'b0, 8'h66, 1, t0);
    k = 0;
    while (!lcd_e && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("rst_mid_pulse_seen", lcd_e, 1);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_lcd_e", lcd_e, 0);
    chk("rst_mid_lcd_d", lcd_d, 0);
    chk("rst_mid_buf_full", buf_full, 1);
    chk("rst_mid_overflow", overflow, 0);
    chk("rst_mid_init_done", init_done, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    obs_q.delete();
    mon_en = 1'b1;
`ifdef LCD_INIT_EN
    init_seq("reinit");
`endif
    repeat (2 * T_CLR) @(posedge clk);
    chk("rst_no_byte", obs_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
